// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//   Byte-addressable, word-organised data RAM for the single-cycle RV32 cpu.
//   Services LB/LH/LW/LBU/LHU loads and SB/SH/SW stores, selected by the
//   instruction's funct3 field (memop). The top-level address decoder asserts
//   we only for the DATA region and muxes dataout onto the cpu read bus.
//
// Parameters
//   ADDR_WIDTH  byte-address bits decoded (17 -> 128 KiB); higher bits ignored
//
// Ports
//   clock       in   1   single clock, all state changes on posedge
//   reset       in   1   asynchronous active-low; clears output regs, not RAM
//   addr        in   32  byte address (word index addr[ADDR_WIDTH-1:2])
//   datain      in   32  store data (SB [7:0], SH [15:0], SW [31:0])
//   memop       in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   we          in   1   write enable, active-high
//   misaligned  out  1   (only with DATA_MEM_MISALIGN_EN) registered flag
//   dataout     out  32  registered, sign/zero-extended load result
//
// Configuration
//   DATA_MEM_MISALIGN_EN  when defined, misaligned H/HU/W accesses are
//                         flagged, return zero and block the store. When
//                         undefined, low address bits are silently truncated.
//
// Timing
//   Loads are synchronous with one cycle of latency. A load and a store to
//   the same word on the same edge is read-first: dataout carries the
//   pre-store contents.
// -----------------------------------------------------------------------------
module data_mem #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic [2:0]  memop,
   input  logic        we,
`ifdef DATA_MEM_MISALIGN_EN
   output logic        misaligned,
`endif
   output logic [31:0] dataout
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   // ---------------------------------------------------------------------
   // Address split
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       byte_off;
   logic             unused_addr_hi;

   assign word_idx = addr[ADDR_WIDTH-1:2];
   assign byte_off = addr[1:0];
   // Bits above the decoded window alias onto the same RAM.
   assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

   // ---------------------------------------------------------------------
   // Operation decode
   // ---------------------------------------------------------------------
   logic is_half;
   logic is_word;
   logic is_store_op;
   logic mis_now;

   assign is_half     = (memop == OP_H) || (memop == OP_HU);
   assign is_word     = (memop == OP_W);
   assign is_store_op = (memop == OP_B) || (memop == OP_H) || (memop == OP_W);

`ifdef DATA_MEM_MISALIGN_EN
   assign mis_now = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
   assign mis_now = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Store lane enables and lane data
   //   Store data is replicated across lanes so each lane only has to pick
   //   its own byte; the enables decide which lanes actually commit.
   //   The reset level is sampled at the edge so stores are dropped while
   //   reset is held low.
   // ---------------------------------------------------------------------
   logic       wr_en;
   logic [3:0] lane_we;
   logic [31:0] lane_wdata;

   assign wr_en = we && reset && is_store_op && !mis_now;

   always_comb begin
      lane_we    = 4'b0000;
      lane_wdata = datain;
      unique case (memop[1:0])
         2'b00:   lane_wdata = {4{datain[7:0]}};
         2'b01:   lane_wdata = {2{datain[15:0]}};
         default: lane_wdata = datain;
      endcase
      if (wr_en) begin
         unique case (memop[1:0])
            2'b00:   lane_we[byte_off] = 1'b1;
            2'b01:   lane_we = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_we = 4'b1111;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Byte lanes
   //   Lane k holds byte k of the little-endian word. The combinational read
   //   of each lane sees the contents before this edge's store, which gives
   //   read-first behaviour once the result is registered below.
   // ---------------------------------------------------------------------
   logic [31:0] rd_word;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clock) begin
         if (lane_we[k]) begin
            mem[word_idx] <= lane_wdata[8*k +: 8];
         end
      end

      assign rd_word[8*k +: 8] = mem[word_idx];
   end

   // ---------------------------------------------------------------------
   // Load extraction and extension
   // ---------------------------------------------------------------------
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;

   always_comb begin
      rd_byte = rd_word[7:0];
      unique case (byte_off)
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         2'd3: rd_byte = rd_word[31:24];
      endcase
      // addr[0] does not participate: halfwords come from addr[1]*2.
      rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      load_val = 32'h0;
      if (!mis_now) begin
         case (memop)
            OP_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_BU:   load_val = {24'h0, rd_byte};
            OP_H:    load_val = {{16{rd_half[15]}}, rd_half};
            OP_HU:   load_val = {16'h0, rd_half};
            OP_W:    load_val = rd_word;
            default: load_val = 32'h0;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dataout <= 32'h0;
      end else begin
         dataout <= load_val;
      end
   end

`ifdef DATA_MEM_MISALIGN_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         misaligned <= 1'b0;
      end else begin
         misaligned <= mis_now;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
//   Self-checking bench for data_mem. Stimulus is driven on the falling edge;
//   every cycle pushes the expected registered result onto exp_q, and a
//   monitor pops and compares it just after the following rising edge.
//   Expected values come from spec constants or a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_data_mem;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] datain;
   logic [2:0]  memop;
   logic        we;
   logic [31:0] dataout;
`ifdef DATA_MEM_MISALIGN_EN
   logic        misaligned;
`endif

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   data_mem #(.ADDR_WIDTH(17)) dut (
      .clock      (clock),
      .reset      (reset),
      .addr       (addr),
      .datain     (datain),
      .memop      (memop),
      .we         (we),
`ifdef DATA_MEM_MISALIGN_EN
      .misaligned (misaligned),
`endif
      .dataout    (dataout)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic        mis_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) begin
      logic [31:0] e;
      string       t;
      logic        m;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         m = mis_q.pop_front();
         check_eq(t, dataout, e);
`ifdef DATA_MEM_MISALIGN_EN
         check_eq({t, "_mis"}, {31'h0, misaligned}, {31'h0, m});
`else
         if (m) check_eq({t, "_mis_model"}, 32'h1, 32'h0);
`endif
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] mm [int];

   function automatic logic model_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_EN
      if ((op == OP_H || op == OP_HU) && a[0]) return 1'b1;
      if (op == OP_W && a[1:0] != 2'b00) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [7:0] model_byte(input int key);
      if (mm.exists(key)) return mm[key];
      return 8'h00;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
      int          base;
      int          off;
      logic [7:0]  b;
      logic [15:0] h;
      base = int'(a & 32'h0001_FFFC);
      off  = int'(a[1:0]);
      b    = model_byte(base + off);
      h    = {model_byte(base + (a[1] ? 3 : 1)), model_byte(base + (a[1] ? 2 : 0))};
      if (model_mis(op, a)) return 32'h0;
      case (op)
         OP_B:    return {{24{b[7]}}, b};
         OP_BU:   return {24'h0, b};
         OP_H:    return {{16{h[15]}}, h};
         OP_HU:   return {16'h0, h};
         OP_W:    return {model_byte(base + 3), model_byte(base + 2),
                          model_byte(base + 1), model_byte(base)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      int base;
      int h;
      base = int'(a & 32'h0001_FFFC);
      h    = a[1] ? 2 : 0;
      if (model_mis(op, a)) return;
      case (op)
         OP_B: mm[base + int'(a[1:0])] = d[7:0];
         OP_H: begin
            mm[base + h]     = d[7:0];
            mm[base + h + 1] = d[15:8];
         end
         OP_W: begin
            mm[base]     = d[7:0];
            mm[base + 1] = d[15:8];
            mm[base + 2] = d[23:16];
            mm[base + 3] = d[31:24];
         end
         default: ;
      endcase
   endtask

   // ---------------- driver ----------------
   // Drives one cycle at the falling edge. use_c selects a literal expected
   // value instead of the model result.
   task automatic cyc(input logic w, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d, input string tag,
                      input logic use_c, input logic [31:0] cv);
      logic [31:0] e;
      logic        m;
      we     = w;
      memop  = op;
      addr   = a;
      datain = d;
      if (!reset) begin
         e = 32'h0;
         m = 1'b0;
      end else begin
         e = use_c ? cv : model_load(op, a);
         m = model_mis(op, a);
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
      mis_q.push_back(m);
      if (reset && w && (op == OP_B || op == OP_H || op == OP_W)) model_store(op, a, d);
      @(negedge clock);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [2:0] ops [8];
      ops = '{OP_B, OP_H, OP_W, OP_BU, OP_HU, 3'b011, 3'b110, 3'b111};
      reset  = 1'b1;
      we     = 1'b0;
      memop  = OP_W;
      addr   = 32'h0;
      datain = 32'h0;
      #1 reset = 1'b0;
      #1 check_eq("rst_init", dataout, 32'h0);
      @(negedge clock);

      // Stores under reset are dropped; dataout held at zero.
      for (int i = 0; i < 3; i++) cyc(1, OP_W, 32'h10, 32'hDEADBEEF, "rst_sw", 1, 32'h0);
      reset = 1'b1;
      cyc(0, OP_W, 32'h10, 32'h0, "t1_lw", 1, 32'h0);

      // Load extension variants.
      cyc(1, OP_W,  32'h20, 32'h8899AABB, "t2_sw",  0, 32'h0);
      cyc(0, OP_B,  32'h20, 32'h0, "t2_lb",  1, 32'hFFFFFFBB);
      cyc(0, OP_BU, 32'h23, 32'h0, "t2_lbu", 1, 32'h00000088);
      cyc(0, OP_H,  32'h22, 32'h0, "t2_lh",  1, 32'hFFFF8899);
      cyc(0, OP_HU, 32'h20, 32'h0, "t2_lhu", 1, 32'h0000AABB);
      cyc(0, OP_W,  32'h20, 32'h0, "t2_lw",  1, 32'h8899AABB);

      // Partial stores merge into the word.
      cyc(1, OP_W, 32'h40, 32'h00000000, "t3_sw", 0, 32'h0);
      cyc(1, OP_B, 32'h41, 32'hFFFFFF5A, "t3_sb", 0, 32'h0);
      cyc(1, OP_H, 32'h42, 32'hFFFF1234, "t3_sh", 0, 32'h0);
      cyc(0, OP_W, 32'h40, 32'h0, "t3_lw", 1, 32'h12345A00);

      // Read-first on same-edge read and write.
      cyc(1, OP_W, 32'h80, 32'h11111111, "t4_sw1", 0, 32'h0);
      cyc(1, OP_W, 32'h80, 32'h22222222, "t4_rdw", 1, 32'h11111111);
      cyc(0, OP_W, 32'h80, 32'h0, "t4_lw", 1, 32'h22222222);

      // Invalid memop: no store, zero load.
      cyc(1, 3'b011, 32'h40, 32'hFFFFFFFF, "t5_bad", 1, 32'h0);
      cyc(0, OP_W,   32'h40, 32'h0, "t5_lw", 1, 32'h12345A00);
      cyc(0, 3'b111, 32'h40, 32'h0, "t5_op7", 1, 32'h0);

      // Address aliasing above ADDR_WIDTH.
      cyc(1, OP_W, 32'h0002_0050, 32'hCAFEF00D, "alias_sw", 0, 32'h0);
      cyc(0, OP_W, 32'h0000_0050, 32'h0, "alias_lw", 1, 32'hCAFEF00D);
      cyc(0, OP_W, 32'hFFFE_0050, 32'h0, "alias_hi", 1, 32'hCAFEF00D);

      // Asynchronous reset mid-cycle clears dataout immediately, RAM kept.
      cyc(0, OP_W, 32'h20, 32'h0, "pre_rst", 1, 32'h8899AABB);
      @(posedge clock);
      #2 reset = 1'b0;
      #1 check_eq("rst_async", dataout, 32'h0);
      @(negedge clock);
      cyc(1, OP_W, 32'h20, 32'h0, "rst_wr_blk", 1, 32'h0);
      reset = 1'b1;
      cyc(0, OP_W, 32'h20, 32'h0, "rst_keep", 1, 32'h8899AABB);

`ifdef DATA_MEM_MISALIGN_EN
      cyc(0, OP_W, 32'h42, 32'h0, "t6_lw_mis", 1, 32'h0);
      cyc(1, OP_H, 32'h41, 32'hFFFFFFFF, "t6_sh_mis", 1, 32'h0);
      cyc(0, OP_W, 32'h40, 32'h0, "t6_lw", 1, 32'h12345A00);
`else
      cyc(0, OP_W, 32'h42, 32'h0, "t6_lw_trunc", 1, 32'h12345A00);
      cyc(1, OP_H, 32'h41, 32'h0000ABCD, "t6_sh_trunc", 0, 32'h0);
      cyc(0, OP_W, 32'h40, 32'h0, "t6_lw", 1, 32'h1234ABCD);
`endif

      // Random traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 17);
         cyc(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], a, $urandom,
             "rnd", 0, 32'h0);
      end

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
